// File: rtl/rvc_asap_5pl_vga_ctrl_if.sv
// Frame-buffer read port B and video output bundle for the VGA controller.
// master: the controller (drives address and pixels, reads memory data).
// slave:  the memory/display side (returns read data, consumes video).
interface rvc_asap_5pl_vga_ctrl_if;
   logic [13:0] vga_address;
   logic [31:0] vga_rd_data;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;
   logic        h_sync;
   logic        v_sync;
   logic        frame_start;

   modport master (
      output vga_address,
      input  vga_rd_data,
      output red,
      output green,
      output blue,
      output h_sync,
      output v_sync,
      output frame_start
   );

   modport slave (
      input  vga_address,
      output vga_rd_data,
      input  red,
      input  green,
      input  blue,
      input  h_sync,
      input  v_sync,
      input  frame_start
   );
endinterface

// File: rtl/rvc_asap_5pl_vga_ctrl.sv
// VGA 640x480@60Hz timing generator and 1 bpp pixel fetcher.
// Raster counters -> registered word address -> memory (1-cycle registered
// read) -> registered RGB. Syncs, visible and frame_start ride a shift chain
// so every output describes the same raster position, 3 cycles after the
// counters.
// Optional feature macro: RVC_VGA_DOUBLE_SCAN_EN (320x240 bitmap, each pixel
// shown as a 2x2 block). Undefined: 640x480 1:1 bitmap.
module rvc_asap_5pl_vga_ctrl #(
   parameter int          H_VISIBLE = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_VISIBLE = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter logic [11:0] FG_COLOR  = 12'hFFF,
   parameter logic [11:0] BG_COLOR  = 12'h000
) (
   input logic                     clock,
   input logic                     rst,
   rvc_asap_5pl_vga_ctrl_if.master vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0]  h_cnt_r;
   logic [9:0]  v_cnt_r;
   logic        visible_s;
   logic        hs_raw_s;
   logic        vs_raw_s;
   logic        fs_raw_s;
   logic [13:0] line_base_s;
   logic [13:0] addr_s;
   logic [4:0]  x_s;
   logic        pixel_bit_s;
   logic [11:0] rgb_s;

   logic [13:0] addr_r;
   logic [1:0]  vis_d_r;   // [0] = 1 cycle late, [1] = 2 cycles late (matches read data)
   logic [2:0]  hs_d_r;
   logic [2:0]  vs_d_r;
   logic [2:0]  fs_d_r;
   logic [4:0]  x_d1_r;
   logic [4:0]  x_d2_r;
   logic [11:0] rgb_r;

   // Free-running raster position; both counters wrap together at the frame end.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         h_cnt_r <= 10'd0;
         v_cnt_r <= 10'd0;
      end else if (h_cnt_r == H_LAST) begin
         h_cnt_r <= 10'd0;
         if (v_cnt_r == V_LAST) begin
            v_cnt_r <= 10'd0;
         end else begin
            v_cnt_r <= v_cnt_r + 10'd1;
         end
      end else begin
         h_cnt_r <= h_cnt_r + 10'd1;
      end
   end

   // Position decode: visible window, raw active-low syncs, frame origin.
   always_comb begin
      visible_s = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
      hs_raw_s  = !((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
      vs_raw_s  = !((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
      fs_raw_s  = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
   end

   // Word address and in-word bit index for the current raster position.
   always_comb begin
      line_base_s = 14'd0;
      addr_s      = 14'd0;
`ifdef RVC_VGA_DOUBLE_SCAN_EN
      // 10 words per bitmap row; each bitmap row is shown on two lines.
      line_base_s = ({5'd0, v_cnt_r[9:1]} << 4'd3) + ({5'd0, v_cnt_r[9:1]} << 4'd1);
      x_s         = h_cnt_r[5:1];
      if (visible_s) begin
         addr_s = line_base_s + {10'd0, h_cnt_r[9:6]};
      end else begin
         addr_s = 14'd0;
      end
`else
      // 20 words per line, multiply by 20 as shift-and-add.
      line_base_s = ({4'd0, v_cnt_r} << 4'd4) + ({4'd0, v_cnt_r} << 4'd2);
      x_s         = h_cnt_r[4:0];
      if (visible_s) begin
         addr_s = line_base_s + {9'd0, h_cnt_r[9:5]};
      end else begin
         addr_s = 14'd0;
      end
`endif
   end

   // Address stage plus the chain that keeps position flags aligned with read data.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         addr_r  <= 14'd0;
         vis_d_r <= 2'b00;
         hs_d_r  <= 3'b111;
         vs_d_r  <= 3'b111;
         fs_d_r  <= 3'b000;
         x_d1_r  <= 5'd0;
         x_d2_r  <= 5'd0;
      end else begin
         addr_r  <= addr_s;
         vis_d_r <= {vis_d_r[0], visible_s};
         hs_d_r  <= {hs_d_r[1:0], hs_raw_s};
         vs_d_r  <= {vs_d_r[1:0], vs_raw_s};
         fs_d_r  <= {fs_d_r[1:0], fs_raw_s};
         x_d1_r  <= x_s;
         x_d2_r  <= x_d1_r;
      end
   end

   // Pixel colour from the returned word; blanking forces black.
   always_comb begin
      pixel_bit_s = vga.vga_rd_data[x_d2_r];
      if (vis_d_r[1]) begin
         if (pixel_bit_s) begin
            rgb_s = FG_COLOR;
         end else begin
            rgb_s = BG_COLOR;
         end
      end else begin
         rgb_s = 12'h000;
      end
   end

   // Output pixel register, same stage as the third sync/frame_start delay.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         rgb_r <= 12'h000;
      end else begin
         rgb_r <= rgb_s;
      end
   end

   assign vga.vga_address = addr_r;
   assign vga.red         = rgb_r[11:8];
   assign vga.green       = rgb_r[7:4];
   assign vga.blue        = rgb_r[3:0];
   assign vga.h_sync      = hs_d_r[2];
   assign vga.v_sync      = vs_d_r[2];
   assign vga.frame_start = fs_d_r[2];

endmodule
